// File: rtl/result_checker.sv
// Sweeps result and golden memories in lock-step after a start pulse, counting word mismatches
// and latching the lowest failing address; reports pass/fail once the last compare lands.
module result_checker #(
  parameter int unsigned DATA_W = 22,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] res_rdata,
  input  logic [DATA_W-1:0] gold_rdata,
  output logic              busy,
  output logic              check_done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_vld
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W:0]   err_q, err_d;
  logic [ADDR_W-1:0] ferr_addr_q, ferr_addr_d;
  logic              ferr_vld_q, ferr_vld_d;

  // In-flight read tracking: the last stage lines up with the memory read data.
  logic [RD_LAT-1:0] pipe_vld_q;
  logic [ADDR_W-1:0] pipe_addr_q [RD_LAT];

  logic              start_ok;
  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic              mismatch;
  logic              last_cmp;

  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
  assign cmp_vld  = pipe_vld_q[RD_LAT-1];
  assign cmp_addr = pipe_addr_q[RD_LAT-1];
  assign mismatch = cmp_vld && (res_rdata != gold_rdata);
  assign last_cmp = cmp_vld && (cmp_addr == LastAddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRead;
      StRead:  if (addr_q == LastAddr) state_d = StDrain;
      StDrain: if (last_cmp) state_d = StDone;
      StDone:  if (start) state_d = StRead;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    rd_en_d     = rd_en_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    ferr_addr_d = ferr_addr_q;
    ferr_vld_d  = ferr_vld_q;
    if (start_ok) begin
      addr_d      = '0;
      rd_en_d     = 1'b1;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      err_d       = '0;
      ferr_addr_d = '0;
      ferr_vld_d  = 1'b0;
    end else begin
      if (state_q == StRead) begin
        if (addr_q == LastAddr) begin
          rd_en_d = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      if (mismatch) begin
        err_d = err_q + (ADDR_W + 1)'(1);
        if (!ferr_vld_q) begin
          ferr_addr_d = cmp_addr;
          ferr_vld_d  = 1'b1;
        end
      end
      // The final compare's mismatch is folded in before pass is decided.
      if (last_cmp) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        pass_d = (err_d == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_vld_q  <= 1'b0;
      pipe_vld_q  <= '0;
    end else begin
      addr_q        <= addr_d;
      rd_en_q       <= rd_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      err_q         <= err_d;
      ferr_addr_q   <= ferr_addr_d;
      ferr_vld_q    <= ferr_vld_d;
      pipe_vld_q[0] <= rd_en_q;
      for (int i = 1; i < RD_LAT; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_addr_q[0] <= addr_q;
    for (int i = 1; i < RD_LAT; i++) pipe_addr_q[i] <= pipe_addr_q[i-1];
  end

  assign mem_addr       = addr_q;
  assign mem_rd_en      = rd_en_q;
  assign busy           = busy_q;
  assign check_done     = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_vld  = ferr_vld_q;

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: three instances (16/lat1, 16/lat3, 4096/lat1) fed by behavioural
// memories; table vectors, hand-written corner sequences and randomized sweeps vs a model.
module tb_result_checker;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start [NI];
  logic [11:0] mem_addr [NI];
  logic        mem_rd_en [NI];
  logic [21:0] res_rdata [NI];
  logic [21:0] gold_rdata [NI];
  logic        busy [NI];
  logic        check_done [NI];
  logic        pass [NI];
  logic [12:0] err_cnt [NI];
  logic [11:0] first_err_addr [NI];
  logic        first_err_vld [NI];

  int dep [NI] = '{16, 16, 4096};
  int lat [NI] = '{1, 3, 1};

  logic [21:0] res_mem  [NI][4096];
  logic [21:0] gold_mem [NI][4096];
  logic [21:0] rp_res   [NI][4];
  logic [21:0] rp_gold  [NI][4];

  int n_checks = 0;
  int n_errors = 0;

  int got_lat, got_k;
  bit got_addr_ok;

  always #5 clk = ~clk;

  result_checker #(.DATA_W(22), .DEPTH(16), .ADDR_W(12), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .mem_addr(mem_addr[0]), .mem_rd_en(mem_rd_en[0]),
    .res_rdata(res_rdata[0]), .gold_rdata(gold_rdata[0]), .busy(busy[0]),
    .check_done(check_done[0]), .pass(pass[0]), .err_cnt(err_cnt[0]),
    .first_err_addr(first_err_addr[0]), .first_err_vld(first_err_vld[0])
  );
  result_checker #(.DATA_W(22), .DEPTH(16), .ADDR_W(12), .RD_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .mem_addr(mem_addr[1]), .mem_rd_en(mem_rd_en[1]),
    .res_rdata(res_rdata[1]), .gold_rdata(gold_rdata[1]), .busy(busy[1]),
    .check_done(check_done[1]), .pass(pass[1]), .err_cnt(err_cnt[1]),
    .first_err_addr(first_err_addr[1]), .first_err_vld(first_err_vld[1])
  );
  result_checker #(.DATA_W(22), .DEPTH(4096), .ADDR_W(12), .RD_LAT(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .mem_addr(mem_addr[2]), .mem_rd_en(mem_rd_en[2]),
    .res_rdata(res_rdata[2]), .gold_rdata(gold_rdata[2]), .busy(busy[2]),
    .check_done(check_done[2]), .pass(pass[2]), .err_cnt(err_cnt[2]),
    .first_err_addr(first_err_addr[2]), .first_err_vld(first_err_vld[2])
  );

  // Synchronous-read memories: stage s holds data read s+1 edges ago.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      for (int s = 3; s > 0; s--) begin
        rp_res[i][s]  <= rp_res[i][s-1];
        rp_gold[i][s] <= rp_gold[i][s-1];
      end
      rp_res[i][0]  <= res_mem[i][mem_addr[i]];
      rp_gold[i][0] <= gold_mem[i][mem_addr[i]];
    end
  end

  assign res_rdata[0]  = rp_res[0][0];
  assign gold_rdata[0] = rp_gold[0][0];
  assign res_rdata[1]  = rp_res[1][2];
  assign gold_rdata[1] = rp_gold[1][2];
  assign res_rdata[2]  = rp_res[2][0];
  assign gold_rdata[2] = rp_gold[2][0];

  typedef struct {
    int inst;
    bit all_bad;
    int a0, a1, a2;
    int e_err, e_first, e_vld, e_pass, e_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [21:0] flip_val();
    return 22'($urandom_range(1, 22'h3f_ffff));
  endfunction

  task automatic fill(input int i, input bit all_bad, input int a0, input int a1, input int a2);
    for (int a = 0; a < dep[i]; a++) begin
      gold_mem[i][a] = 22'($urandom);
      res_mem[i][a]  = all_bad ? (gold_mem[i][a] ^ flip_val()) : gold_mem[i][a];
    end
    if (a0 >= 0) res_mem[i][a0] = gold_mem[i][a0] ^ flip_val();
    if (a1 >= 0) res_mem[i][a1] = gold_mem[i][a1] ^ flip_val();
    if (a2 >= 0) res_mem[i][a2] = gold_mem[i][a2] ^ flip_val();
  endtask

  task automatic chk_reset_state(input string name, input int i);
    chk(name, {busy[i], check_done[i], pass[i], first_err_vld[i], mem_rd_en[i], err_cnt[i],
               first_err_addr[i], mem_addr[i]}, 0);
  endtask

  // Starts a sweep on instance i and waits (bounded) for check_done.
  task automatic sweep(input int i);
    int cyc;
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
    chk("start_edge_state", {busy[i], check_done[i], pass[i], first_err_vld[i], mem_rd_en[i],
                             err_cnt[i], mem_addr[i]}, {5'b10001, 13'd0, 12'd0});
    got_k = 0;
    got_addr_ok = 1'b1;
    cyc = 0;
    if (mem_rd_en[i]) begin
      if (mem_addr[i] != 12'(got_k)) got_addr_ok = 1'b0;
      got_k++;
    end
    while (!check_done[i] && cyc < dep[i] + lat[i] + 20) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_rd_en[i]) begin
        if (mem_addr[i] != 12'(got_k)) got_addr_ok = 1'b0;
        got_k++;
      end
    end
    got_lat = check_done[i] ? cyc : -1;
  endtask

  task automatic chk_results(input string tag, input int i, input int e_err, input int e_first,
                             input int e_vld, input int e_pass, input int e_lat);
    chk({tag, ".latency"}, got_lat, e_lat);
    chk({tag, ".addr_seq"}, {got_addr_ok, 16'(got_k)}, {1'b1, 16'(dep[i])});
    chk({tag, ".err_cnt"}, err_cnt[i], e_err);
    chk({tag, ".first_err_addr"}, first_err_addr[i], e_first);
    chk({tag, ".first_err_vld"}, first_err_vld[i], e_vld);
    chk({tag, ".pass_busy"}, {pass[i], busy[i]}, {e_pass[0], 1'b0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m_err, m_first;
    vecs[0] = '{0, 1'b0, -1, -1, -1,  0,  0, 0, 1,   17};
    vecs[1] = '{0, 1'b1, -1, -1, -1, 16,  0, 1, 0,   17};
    vecs[2] = '{1, 1'b0, 15, -1, -1,  1, 15, 1, 0,   19};
    vecs[3] = '{0, 1'b0,  2,  7, 11,  3,  2, 1, 0,   17};
    vecs[4] = '{0, 1'b0, -1, -1, -1,  0,  0, 0, 1,   17};
    vecs[5] = '{1, 1'b0,  0, -1, -1,  1,  0, 1, 0,   19};
    vecs[6] = '{2, 1'b0,  5, 4095, -1, 2, 5, 1, 0, 4097};

    for (int i = 0; i < NI; i++) start[i] = 1'b0;
    for (int i = 0; i < NI; i++) fill(i, 1'b0, -1, -1, -1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NI; i++) chk_reset_state("reset_outputs", i);

    for (int v = 0; v < 7; v++) begin
      fill(vecs[v].inst, vecs[v].all_bad, vecs[v].a0, vecs[v].a1, vecs[v].a2);
      sweep(vecs[v].inst);
      chk_results($sformatf("vec%0d", v), vecs[v].inst, vecs[v].e_err, vecs[v].e_first,
                  vecs[v].e_vld, vecs[v].e_pass, vecs[v].e_lat);
    end

    // A second start mid-sweep must not restart or disturb the sweep.
    fill(0, 1'b0, 9, -1, -1);
    fork
      sweep(0);
      begin
        repeat (6) @(posedge clk);
        #2 start[0] = 1'b1;
        @(posedge clk); #2 start[0] = 1'b0;
      end
    join
    chk_results("busy_start", 0, 1, 9, 1, 0, 17);

    // Start ignored at cycle 5, then rst at cycle 8 aborts everything.
    fill(0, 1'b1, -1, -1, -1);
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk_reset_state("mid_sweep_rst", 0);
    repeat (4) @(posedge clk);
    #1 chk_reset_state("after_rst_idle", 0);
    fill(0, 1'b0, 4, -1, -1);
    sweep(0);
    chk_results("post_rst_sweep", 0, 1, 4, 1, 0, 17);

    // rst and start together: rst wins.
    @(posedge clk); #1 begin rst = 1'b1; start[0] = 1'b1; end
    @(posedge clk); #1 begin rst = 1'b0; start[0] = 1'b0; end
    chk_reset_state("rst_beats_start", 0);
    repeat (3) @(posedge clk);
    #1 chk_reset_state("rst_beats_start_idle", 0);

    // Randomized sweeps checked against a direct count over the memory contents.
    for (int t = 0; t < 14; t++) begin
      int i;
      i = (t == 13) ? 2 : (t % 2);
      fill(i, 1'b0, -1, -1, -1);
      for (int a = 0; a < dep[i]; a++)
        if ($urandom_range(0, 3) == 0) res_mem[i][a] = gold_mem[i][a] ^ flip_val();
      m_err = 0;
      m_first = -1;
      for (int a = 0; a < dep[i]; a++) begin
        if (res_mem[i][a] != gold_mem[i][a]) begin
          m_err++;
          if (m_first < 0) m_first = a;
        end
      end
      sweep(i);
      chk_results($sformatf("rand%0d", t), i, m_err, (m_first < 0) ? 0 : m_first,
                  (m_first < 0) ? 0 : 1, (m_err == 0) ? 1 : 0, dep[i] + lat[i]);
    end

    // Results hold in DONE until the next start.
    repeat (10) @(posedge clk);
    #1 chk("done_hold", {check_done[2], busy[2]}, 2'b10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
